// File: rtl/mp3_joint_stereo_pipe_if.sv
// mp3_joint_stereo_pipe_if: sample-pair stream, granule config and error flag of the joint-stereo stage.
interface mp3_joint_stereo_pipe_if #(
   parameter int DATA_W = 16,
   parameter int IDX_W  = 10
);
   logic [1:0]        mode;
   logic [1:0]        mode_ext;
   logic [IDX_W-1:0]  is_bound;
   logic              s_valid;
   logic              s_ready;
   logic [DATA_W-1:0] s_ch0;
   logic [DATA_W-1:0] s_ch1;
   logic [2:0]        s_is_pos;
   logic              s_last;
   logic              m_valid;
   logic              m_ready;
   logic [DATA_W-1:0] m_ch0;
   logic [DATA_W-1:0] m_ch1;
   logic              m_last;
   logic              err;
   modport slave (
      input  mode, mode_ext, is_bound, s_valid, s_ch0, s_ch1, s_is_pos, s_last, m_ready,
      output s_ready, m_valid, m_ch0, m_ch1, m_last, err
   );
   modport master (
      output mode, mode_ext, is_bound, s_valid, s_ch0, s_ch1, s_is_pos, s_last, m_ready,
      input  s_ready, m_valid, m_ch0, m_ch1, m_last, err
   );
endinterface

// File: rtl/mp3_joint_stereo_pipe.sv
// mp3_joint_stereo_pipe: MS / intensity-stereo reconstruction as a 3-stage valid/ready pipe.
// Define MP3_JS_IS_EN to build the intensity-stereo path; otherwise IS samples fall back to MS or passthrough.
module mp3_joint_stereo_pipe #(
   parameter int DATA_W = 16,
   parameter int FRAC_W = 14,
   parameter int NSAMP  = 576,
   parameter int IDX_W  = 10
) (
   input logic clk,
   input logic rst,
   mp3_joint_stereo_pipe_if.slave bus
);
   localparam int SW = DATA_W + 1;
   localparam int CW = FRAC_W + 2;
   localparam int PW = SW + CW;
   localparam logic signed [CW-1:0] ONE  = CW'(1 << FRAC_W);
   localparam logic signed [CW-1:0] KMS  = CW'($rtoi(0.7071067811865476 * (2.0 ** FRAC_W) + 0.5));
   localparam logic signed [PW-1:0] HALF = PW'(1 << (FRAC_W - 1));
   localparam logic signed [PW-1:0] MAXV = PW'((1 << (DATA_W - 1)) - 1);
   localparam logic signed [PW-1:0] MINV = -MAXV - PW'(1);
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NSAMP - 1);

   typedef enum logic {IDLE, RUN} state_t;

   function automatic logic [DATA_W-1:0] rnd_sat(input logic signed [PW-1:0] p);
      logic signed [PW-1:0] r;
      r = (p + HALF) >>> FRAC_W;
      return (r > MAXV) ? MAXV[DATA_W-1:0] : (r < MINV) ? MINV[DATA_W-1:0] : r[DATA_W-1:0];
   endfunction

   state_t state;
   logic [IDX_W-1:0] cnt;
   logic [1:0] mode_q, ext_q, mode_u, ext_u;
   logic idle, en, acc, joint, is_sel, ms_sel;
   logic signed [SW-1:0] c0e, c1e, x, y, x1, y1;
   logic signed [CW-1:0] tl, tr, kl, kr, kl1, kr1;
   logic signed [PW-1:0] pl2, pr2;
   logic v1, v2, last1, last2;

   assign en = !bus.m_valid || bus.m_ready;
   assign acc = bus.s_valid && en;
   assign bus.s_ready = en;
   assign idle = state == IDLE;
   // The first sample of a granule uses the live config, later ones the copy latched with it.
   assign mode_u = idle ? bus.mode : mode_q;
   assign ext_u = idle ? bus.mode_ext : ext_q;
   assign c0e = SW'($signed(bus.s_ch0));
   assign c1e = SW'($signed(bus.s_ch1));

`ifdef MP3_JS_IS_EN
   logic [IDX_W-1:0] bound_q, bound_u;
   logic signed [CW-1:0] kl_tab [8];

   function automatic int kl_f(input int p);
      real r;
      r = p == 1 ? 0.21132486540518713 : p == 2 ? 0.36602540378443865 : p == 3 ? 0.5 :
          p == 4 ? 0.6339745962155614 : p == 5 ? 0.7886751345948129 : p == 6 ? 1.0 : 0.0;
      return $rtoi(r * (2.0 ** FRAC_W));
   endfunction

   for (genvar i = 0; i < 8; i++) begin : g_tab
      localparam int KV = kl_f(i);
      assign kl_tab[i] = CW'(KV);
   end

   assign bound_u = idle ? bus.is_bound : bound_q;
`endif

   always_comb begin
      joint = mode_u == 2'b01;
      is_sel = 1'b0;
      tl = ONE;
      tr = ONE;
`ifdef MP3_JS_IS_EN
      is_sel = joint && ext_u[0] && cnt >= bound_u && bus.s_is_pos != 3'd7;
      tl = kl_tab[bus.s_is_pos];
      tr = kl_tab[3'd6 - bus.s_is_pos];
`endif
      ms_sel = !is_sel && joint && ext_u[1];
      x = ms_sel ? c0e + c1e : c0e;
      y = ms_sel ? c0e - c1e : is_sel ? c0e : c1e;
      kl = is_sel ? tl : ms_sel ? KMS : ONE;
      kr = is_sel ? tr : ms_sel ? KMS : ONE;
   end

   // Framing: a granule ends on s_last or at NSAMP-1, whichever comes first; disagreement is an error.
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
         cnt <= '0;
         bus.err <= 1'b0;
      end else if (acc) begin
         if (idle) begin
            mode_q <= bus.mode;
            ext_q <= bus.mode_ext;
`ifdef MP3_JS_IS_EN
            bound_q <= bus.is_bound;
`endif
         end
         if (bus.s_last || cnt == LAST_IDX) begin
            state <= IDLE;
            cnt <= '0;
            if (bus.s_last != (cnt == LAST_IDX)) bus.err <= 1'b1;
         end else begin
            state <= RUN;
            cnt <= cnt + 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         v1 <= 1'b0;
         v2 <= 1'b0;
         bus.m_valid <= 1'b0;
         bus.m_ch0 <= '0;
         bus.m_ch1 <= '0;
         bus.m_last <= 1'b0;
      end else if (en) begin
         v1 <= bus.s_valid;
         last1 <= bus.s_last;
         x1 <= x;
         y1 <= y;
         kl1 <= kl;
         kr1 <= kr;
         v2 <= v1;
         last2 <= last1;
         pl2 <= PW'(x1) * PW'(kl1);
         pr2 <= PW'(y1) * PW'(kr1);
         bus.m_valid <= v2;
         if (v2) begin
            bus.m_ch0 <= rnd_sat(pl2);
            bus.m_ch1 <= rnd_sat(pr2);
            bus.m_last <= last2;
         end
      end
   end
endmodule

// File: tb/tb_mp3_joint_stereo_pipe.sv
// tb_mp3_joint_stereo_pipe: directed checks of passthrough, MS, IS, framing, reset and backpressured streaming.
module tb_mp3_joint_stereo_pipe;
   logic clk = 1'b0;
   logic rst = 1'b1;
   int total = 0;
   int bad = 0;
   bit done;
   logic [32:0] outq [$];

   always #5 clk = ~clk;

   mp3_joint_stereo_pipe_if bus ();
   mp3_joint_stereo_pipe dut (.clk(clk), .rst(rst), .bus(bus));

   always @(negedge clk) if (bus.m_valid && bus.m_ready) outq.push_back({bus.m_last, bus.m_ch1, bus.m_ch0});

   task automatic do_reset();
      rst = 1'b1;
      bus.s_valid = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      outq.delete();
   endtask

   task automatic send(input logic [15:0] c0, input logic [15:0] c1, input logic [2:0] p, input logic l);
      int n = 0;
      bus.s_valid = 1'b1;
      bus.s_ch0 = c0;
      bus.s_ch1 = c1;
      bus.s_is_pos = p;
      bus.s_last = l;
      @(negedge clk);
      while (!bus.s_ready && n < 100) begin
         @(negedge clk);
         n++;
      end
      if (!bus.s_ready) begin
         total++;
         bad++;
         $display("FAIL send_timeout got=s_ready_low req=accept");
      end
      @(posedge clk);
      #1;
      bus.s_valid = 1'b0;
   endtask

   task automatic get(output logic [32:0] v);
      int n = 0;
      while (outq.size() == 0 && n < 50) begin
         @(negedge clk);
         n++;
      end
      if (outq.size() == 0) begin
         total++;
         bad++;
         $display("FAIL get_timeout got=none req=sample");
         v = 'x;
      end else v = outq.pop_front();
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      total += 5;
      if (bus.m_valid !== 1'b0) begin bad++; $display("FAIL rst_m_valid got=%b req=0", bus.m_valid); end
      if (bus.m_ch0 !== 16'h0) begin bad++; $display("FAIL rst_m_ch0 got=%h req=0000", bus.m_ch0); end
      if (bus.m_ch1 !== 16'h0) begin bad++; $display("FAIL rst_m_ch1 got=%h req=0000", bus.m_ch1); end
      if (bus.m_last !== 1'b0) begin bad++; $display("FAIL rst_m_last got=%b req=0", bus.m_last); end
      if (bus.err !== 1'b0) begin bad++; $display("FAIL rst_err got=%b req=0", bus.err); end
      rst = 1'b0;
      total++;
      if (bus.s_ready !== 1'b1) begin bad++; $display("FAIL rst_s_ready got=%b req=1", bus.s_ready); end
   endtask

   task automatic test_pass_latency();
      do_reset();
      bus.mode = 2'b00;
      bus.mode_ext = 2'b00;
      bus.m_ready = 1'b1;
      bus.s_valid = 1'b1;
      bus.s_ch0 = 16'h1234;
      bus.s_ch1 = 16'hF00D;
      bus.s_is_pos = 3'd7;
      bus.s_last = 1'b0;
      @(posedge clk);
      #1;
      bus.s_valid = 1'b0;
      total++;
      if (bus.m_valid !== 1'b0) begin bad++; $display("FAIL lat_c1 got=%b req=0", bus.m_valid); end
      @(posedge clk);
      #1;
      total++;
      if (bus.m_valid !== 1'b0) begin bad++; $display("FAIL lat_c2 got=%b req=0", bus.m_valid); end
      @(posedge clk);
      #1;
      total += 4;
      if (bus.m_valid !== 1'b1) begin bad++; $display("FAIL lat_c3 got=%b req=1", bus.m_valid); end
      if (bus.m_ch0 !== 16'h1234) begin bad++; $display("FAIL pass_ch0 got=%h req=1234", bus.m_ch0); end
      if (bus.m_ch1 !== 16'hF00D) begin bad++; $display("FAIL pass_ch1 got=%h req=f00d", bus.m_ch1); end
      if (bus.m_last !== 1'b0) begin bad++; $display("FAIL pass_last got=%b req=0", bus.m_last); end
      @(posedge clk);
      #1;
      total += 2;
      if (bus.m_valid !== 1'b0) begin bad++; $display("FAIL pass_drop got=%b req=0", bus.m_valid); end
      if (bus.m_ch0 !== 16'h1234) begin bad++; $display("FAIL pass_hold got=%h req=1234", bus.m_ch0); end
   endtask

   task automatic test_ms();
      logic [15:0] c0 [6] = '{16'h4000, 16'h7FFF, 16'h8000, 16'h8000, 16'h0001, 16'h0001};
      logic [15:0] c1 [6] = '{16'h0000, 16'h7FFF, 16'h8000, 16'h7FFF, 16'h0000, 16'h0001};
      logic [15:0] e0 [6] = '{16'h2D41, 16'h7FFF, 16'h8000, 16'hFFFF, 16'h0001, 16'h0001};
      logic [15:0] e1 [6] = '{16'h2D41, 16'h0000, 16'h0000, 16'h8000, 16'h0001, 16'h0000};
      logic [32:0] v;
      do_reset();
      bus.mode = 2'b01;
      bus.mode_ext = 2'b10;
      bus.m_ready = 1'b1;
      for (int i = 0; i < 6; i++) send(c0[i], c1[i], 3'd7, 1'b0);
      for (int i = 0; i < 6; i++) begin
         get(v);
         total++;
         if (v[31:0] !== {e1[i], e0[i]})
            begin bad++; $display("FAIL ms_%0d got=%h/%h req=%h/%h", i, v[15:0], v[31:16], e0[i], e1[i]); end
      end
   endtask

   task automatic test_is();
      logic [2:0] p [7] = '{3'd3, 3'd3, 3'd3, 3'd3, 3'd3, 3'd7, 3'd6};
`ifdef MP3_JS_IS_EN
      logic [15:0] e0 [7] = '{16'h4000, 16'h4000, 16'h4000, 16'h4000, 16'h2000, 16'h4000, 16'h4000};
      logic [15:0] e1 [7] = '{16'h1111, 16'h1111, 16'h1111, 16'h1111, 16'h2000, 16'h1111, 16'h0000};
`else
      logic [15:0] e0 [7] = '{16'h4000, 16'h4000, 16'h4000, 16'h4000, 16'h4000, 16'h4000, 16'h4000};
      logic [15:0] e1 [7] = '{16'h1111, 16'h1111, 16'h1111, 16'h1111, 16'h1111, 16'h1111, 16'h1111};
`endif
      logic [32:0] v;
      do_reset();
      bus.mode = 2'b01;
      bus.mode_ext = 2'b01;
      bus.is_bound = 10'd4;
      bus.m_ready = 1'b1;
      for (int i = 0; i < 7; i++) send(16'h4000, 16'h1111, p[i], 1'b0);
      for (int i = 0; i < 7; i++) begin
         get(v);
         total++;
         if (v[31:0] !== {e1[i], e0[i]})
            begin bad++; $display("FAIL is_idx%0d got=%h/%h req=%h/%h", i, v[15:0], v[31:16], e0[i], e1[i]); end
      end
   endtask

   task automatic test_err();
      logic [32:0] v;
      do_reset();
      bus.mode = 2'b00;
      bus.mode_ext = 2'b00;
      bus.m_ready = 1'b1;
      for (int i = 0; i <= 100; i++) begin
         send(16'(i), 16'(i), 3'd7, i == 100);
         if (i == 99) begin
            total++;
            if (bus.err !== 1'b0) begin bad++; $display("FAIL err_early got=%b req=0", bus.err); end
         end
      end
      total++;
      if (bus.err !== 1'b1) begin bad++; $display("FAIL err_short_last got=%b req=1", bus.err); end
      repeat (6) @(posedge clk);
      #1;
      outq.delete();
      bus.mode = 2'b01;
      bus.mode_ext = 2'b10;
      send(16'h4000, 16'h0000, 3'd7, 1'b0);
      get(v);
      total += 2;
      if (v[31:0] !== 32'h2D41_2D41) begin bad++; $display("FAIL err_restart got=%h req=2d412d41", v[31:0]); end
      if (bus.err !== 1'b1) begin bad++; $display("FAIL err_sticky got=%b req=1", bus.err); end
      do_reset();
      bus.mode = 2'b00;
      for (int i = 0; i < 576; i++) begin
         send(16'(i), 16'h0, 3'd7, 1'b0);
         if (i == 574) begin
            total++;
            if (bus.err !== 1'b0) begin bad++; $display("FAIL err_long_early got=%b req=0", bus.err); end
         end
      end
      total++;
      if (bus.err !== 1'b1) begin bad++; $display("FAIL err_missing_last got=%b req=1", bus.err); end
   endtask

   task automatic test_back_to_back();
      int n = 0;
      logic [32:0] e;
      do_reset();
      bus.mode = 2'b00;
      bus.mode_ext = 2'b00;
      bus.m_ready = 1'b1;
      done = 1'b0;
      fork
         begin
            for (int i = 0; i < 576; i++) send(16'(i), 16'(i) ^ 16'hFFFF, 3'd7, i == 575);
            done = 1'b1;
         end
         begin
            while (!done) begin
               @(posedge clk);
               #1;
               bus.m_ready = 1'($urandom_range(0, 1));
            end
         end
      join
      bus.m_ready = 1'b1;
      while (outq.size() < 576 && n < 100) begin
         @(negedge clk);
         n++;
      end
      total += 2;
      if (outq.size() != 576) begin bad++; $display("FAIL stream_count got=%0d req=576", outq.size()); end
      if (bus.err !== 1'b0) begin bad++; $display("FAIL stream_err got=%b req=0", bus.err); end
      for (int i = 0; i < 576 && i < outq.size(); i++) begin
         e = {i == 575, 16'(i) ^ 16'hFFFF, 16'(i)};
         total++;
         if (outq[i] !== e) begin bad++; $display("FAIL stream_%0d got=%h req=%h", i, outq[i], e); end
      end
   endtask

   task automatic test_reset_mid();
      do_reset();
      bus.mode = 2'b00;
      bus.mode_ext = 2'b00;
      bus.m_ready = 1'b0;
      send(16'h0001, 16'h0001, 3'd7, 1'b1);
      send(16'h0002, 16'h0002, 3'd7, 1'b0);
      repeat (4) @(posedge clk);
      #1;
      total += 2;
      if (bus.m_valid !== 1'b1) begin bad++; $display("FAIL mid_pre_valid got=%b req=1", bus.m_valid); end
      if (bus.err !== 1'b1) begin bad++; $display("FAIL mid_pre_err got=%b req=1", bus.err); end
      rst = 1'b1;
      @(posedge clk);
      #1;
      total += 2;
      if (bus.m_valid !== 1'b0) begin bad++; $display("FAIL mid_rst_valid got=%b req=0", bus.m_valid); end
      if (bus.err !== 1'b0) begin bad++; $display("FAIL mid_rst_err got=%b req=0", bus.err); end
      rst = 1'b0;
      outq.delete();
      bus.m_ready = 1'b1;
      repeat (6) @(posedge clk);
      #1;
      total += 2;
      if (outq.size() != 0) begin bad++; $display("FAIL mid_stale got=%0d req=0", outq.size()); end
      if (bus.m_valid !== 1'b0) begin bad++; $display("FAIL mid_idle_valid got=%b req=0", bus.m_valid); end
   endtask

   initial begin
      bus.mode = 2'b00;
      bus.mode_ext = 2'b00;
      bus.is_bound = '0;
      bus.s_valid = 1'b0;
      bus.s_ch0 = '0;
      bus.s_ch1 = '0;
      bus.s_is_pos = 3'd7;
      bus.s_last = 1'b0;
      bus.m_ready = 1'b1;
      test_reset();
      test_pass_latency();
      test_ms();
      test_is();
      test_err();
      test_back_to_back();
      test_reset_mid();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
